// File: rtl/stat_pkg.sv
// Shared types and helpers for the statistics counter bank.
// Holds the report FSM encoding and ASCII formatting constants.
package stat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIGIT,
        ST_SEP,
        ST_CR,
        ST_LF
    } state_t;

    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/stat_hex_ser.sv
// Snapshot of all counters streamed out as one ASCII hex line.
// One character per handshake; out_char is held while stalled.
module stat_hex_ser
    import stat_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                snap,
    input  logic [N-1:0][W-1:0] cnt,
    output logic                out_vld,
    input  logic                out_ready,
    output logic [7:0]          out_char,
    output logic                busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int NW = (W > 4) ? $clog2(W / 4) : 1;
    localparam logic [CW-1:0] CH_LAST  = CW'(N - 1);
    localparam logic [NW-1:0] NIB_LAST = NW'(W / 4 - 1);

    state_t               state, state_n;
    logic [N-1:0][W-1:0]  shadow, src;
    logic [CW-1:0]        ch, ch_n;
    logic [NW-1:0]        nib, nib_n;
    logic                 vld_n;
    logic [7:0]           char_n;
    logic                 xfer;

    assign busy = (state != ST_IDLE);
    assign xfer = out_vld && out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            shadow   <= '0;
            ch       <= '0;
            nib      <= '0;
            out_vld  <= 1'b0;
            out_char <= 8'h00;
        end else begin
            state    <= state_n;
            ch       <= ch_n;
            nib      <= nib_n;
            out_vld  <= vld_n;
            out_char <= char_n;
            if (snap) shadow <= cnt;
        end
    end

    always_comb begin
        state_n = state;
        ch_n    = ch;
        nib_n   = nib;
        vld_n   = out_vld;
        char_n  = out_char;
        src     = shadow;
        unique case (state)
            ST_IDLE: begin
                if (snap) begin
                    state_n = ST_DIGIT;
                    ch_n    = '0;
                    nib_n   = NIB_LAST;
                    vld_n   = 1'b1;
                    // shadow loads this edge, so format from the live values
                    src     = cnt;
                end
            end
            ST_DIGIT: begin
                if (xfer) begin
                    if (nib != '0) begin
                        nib_n = nib - 1'b1;
                    end else if (ch != CH_LAST) begin
                        state_n = ST_SEP;
                        ch_n    = ch + 1'b1;
                    end else begin
                        state_n = ST_CR;
                    end
                end
            end
            ST_SEP: begin
                if (xfer) begin
                    state_n = ST_DIGIT;
                    nib_n   = NIB_LAST;
                end
            end
            ST_CR: begin
                if (xfer) state_n = ST_LF;
            end
            ST_LF: begin
                if (xfer) begin
                    state_n = ST_IDLE;
                    vld_n   = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                vld_n   = 1'b0;
            end
        endcase
        unique case (state_n)
            ST_DIGIT: char_n = hex2ascii(src[ch_n][{nib_n, 2'b00} +: 4]);
            ST_SEP:   char_n = SP;
            ST_CR:    char_n = CR;
            ST_LF:    char_n = LF;
            default:  char_n = out_char;
        endcase
    end

endmodule

// File: rtl/stat_counters.sv
// Bank of saturating event counters with clear, snapshot dump
// over a byte stream, and a registered display tap.
module stat_counters
    import stat_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 16,
    parameter bit CLR_ON_DUMP = 1'b0,
    localparam int SW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [N-1:0]  evt,
    input  logic          clr,
    input  logic          dump,
    input  logic [SW-1:0] disp_sel,
    output logic [W-1:0]  disp_val,
    output logic          out_vld,
    input  logic          out_ready,
    output logic [7:0]    out_char,
    output logic          busy
);

    logic [N-1:0][W-1:0] cnt;
    logic                snap;

    assign snap = dump && !busy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (clr) begin
                    cnt[i] <= '0;
                end else if (CLR_ON_DUMP && snap) begin
                    cnt[i] <= W'(evt[i]);
                end else if (evt[i] && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            disp_val <= '0;
        end else if (32'(disp_sel) < N) begin
            disp_val <= cnt[disp_sel];
        end else begin
            disp_val <= '0;
        end
    end

    stat_hex_ser #(
        .N (N),
        .W (W)
    ) u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .snap      (snap),
        .cnt       (cnt),
        .out_vld   (out_vld),
        .out_ready (out_ready),
        .out_char  (out_char),
        .busy      (busy)
    );

endmodule

// File: doc/stat_counters.md
# stat_counters

Parametrised bank of N saturating event counters with synchronous clear, snapshot-and-dump, and a live display tap. Generalises the fixed per-frame, CRC-error and ARP statistics counters feeding the seg7 display. A `dump` request freezes all counts and streams them as an ASCII hex line over a valid/ready byte interface, suitable for the UART FIFO path. The `disp_sel`/`disp_val` tap selects any counter for the seg7 display.

## Interface
- `N`, 4, number of counter channels (1..16)
- `W`, 16, counter width in bits; multiple of 4, 4..32
- `CLR_ON_DUMP`, 0, 1 = counters cleared at the snapshot cycle
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `evt`  in  N  per-channel increment strobe, one count per cycle high
- `clr`  in  1  synchronous clear of all counters
- `dump`  in  1  request a snapshot and ASCII report
- `disp_sel`  in  $clog2(N) (min 1)  channel for display tap
- `disp_val`  out  W  registered live value of counter `disp_sel`
- `out_vld`  out  1  `out_char` valid
- `out_ready`  in  1  sink accepts `out_char`
- `out_char`  out  8  ASCII character
- `busy`  out  1  report in progress

## Operation
- Counter i: if `clr`, set to 0; else if `evt[i]` and not all-ones, add 1; saturates at 2^W-1 with no wrap.
- `clr` wins over a simultaneous `evt`; that event is lost.
- `dump` is accepted only when `busy`=0. A `dump` while busy is ignored and not queued.
- Accept cycle: copy all counters into shadow registers.
- If `CLR_ON_DUMP`=1, live counters restart at this cycle: an `evt[i]` in the same cycle leaves counter i at 1, otherwise 0.
- Report format: channel 0 first. Each channel is W/4 uppercase hex digits, MSB nibble first. Channels are separated by a single 0x20. The line ends with 0x0D 0x0A. Total characters = N*W/4 + (N-1) + 2.
- Hex mapping: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46.
- FSM states:
  - IDLE: on `dump`, go to DIGIT.
  - DIGIT: after the last nibble, go to SEP if channels remain, else CR.
  - SEP: go to DIGIT.
  - CR: go to LF.
  - LF: go to IDLE.
  - All non-IDLE states advance only on a handshake.
- Handshake: a transfer occurs when `out_vld` & `out_ready`. While `out_vld`=1 and `out_ready`=0, `out_char` holds stable. `out_vld` never drops without a transfer except on reset.
- Events and `clr` during a report update the live counters only. The report shows the shadow values.
- Reset mid-report returns the FSM to IDLE immediately; the partial line is abandoned.
- Reset values: all counters 0, shadows 0, `disp_val`=0, `out_vld`=0, `out_char`=0x00, `busy`=0, state IDLE.

## Timing
- An `evt` or `clr` at cycle t is visible in the counter at t+1.
- `disp_val` at t+2 reflects the counter value and `disp_sel` of t+1 (one register stage after the mux).
- `dump` accepted at t gives `busy`=1 and `out_vld`=1 with the first digit at t+1.
- With `out_ready` held high, one character transfers per cycle; the report occupies N*W/4+N+1 consecutive cycles.
- `busy` falls in the cycle after the LF transfer. A new `dump` is accepted in that same cycle, so the next report's first character appears the following cycle.

## Structure
- Package `stat_pkg` holds:
  - the FSM state enum (IDLE, DIGIT, SEP, CR, LF);
  - ASCII constants SP, CR, LF;
  - function `hex2ascii(logic [3:0]) -> logic [7:0]`.
- Sub-module `stat_hex_ser` contains the shadow registers, FSM, nibble/channel indices and output register. The top holds the counter array and display tap.

## Test plan
- N=4, W=16: reset, 3 `evt[0]` pulses, 0x12 `evt[2]` pulses, then `dump` with `out_ready`=1 -> stream "0003 0000 0012 0000\r\n", 21 characters, `busy` high for exactly 21 cycles.
- `evt[1]` held high for 65540 cycles -> count stays 0xFFFF; `dump` shows "FFFF" for channel 1.
- `clr` and `evt[3]` in the same cycle with counter 3 at 5 -> counter 3 reads 0 next cycle; `disp_sel`=3 gives `disp_val`=0 two cycles later.
- Backpressure: `out_ready` random at 30% -> `out_char` stable during every stall; the character sequence is identical to the unstalled run.
- `CLR_ON_DUMP`=1, counter 0 at 7, with `dump` and `evt[0]` in the same cycle -> report shows 0007, live counter 0 reads 1. A second `dump` during the report is ignored.
- Reset asserted after the 5th character -> next cycle `out_vld`=0, `busy`=0, all counters 0. A new `dump` then yields "0000 0000 0000 0000\r\n".
